// File: rtl/scr1_dmem_resp_pkg.sv
// Package for the data-memory responder.
// Holds the responder FSM encoding, the wait-counter width and the request
// legality check used on the latched request. Also re-exports the SCR1
// memory interface types and type_vector to everything importing it.
package scr1_dmem_resp_pkg;

`include "scr1_memif.svh"
`include "defines.svh"

    localparam int DMEM_AW = `SCR1_DMEM_AWIDTH;
    localparam int WCNT_W  = 4;     // holds LATENCY 0..15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } type_dmem_resp_st_e;

    // Returns 1 when the request must be answered with RDY_ER.
    // Below vec_base: scalar natural-alignment rules.
    // At/above vec_base: only row-aligned WORD (full-row) accesses allowed.
    function automatic logic f_dmem_chk(
        input logic [DMEM_AW-1:0] addr,
        input type_scr1_mem_width_e width,
        input logic [DMEM_AW-1:0] mem_bytes,
        input logic [DMEM_AW-1:0] vec_base,
        input logic [DMEM_AW-1:0] vb
    );
        logic err;
        err = 1'b0;
        if (addr >= mem_bytes) begin
            err = 1'b1;
        end else if (addr < vec_base) begin
            if ((width == SCR1_MEM_WIDTH_HWORD) && addr[0])         err = 1'b1;
            if ((width == SCR1_MEM_WIDTH_WORD) && (addr[1:0] != 0)) err = 1'b1;
        end else begin
            if (width != SCR1_MEM_WIDTH_WORD)   err = 1'b1;
            if ((addr & (vb - 1'b1)) != '0)     err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/defines.svh
// Codebase-wide vector type: one full memory row moved by a vector access.
`ifndef SCR1_DEFINES_SVH
`define SCR1_DEFINES_SVH

typedef logic [127:0] type_vector;

`endif

// File: rtl/scr1_dmem_resp_ram.sv
// Single-port row memory for the data-memory responder.
//   clk   : clock
//   en    : access strobe (read sample or write commit this edge)
//   we    : 1 = write with byte enables, 0 = registered read
//   addr  : row index
//   be    : per-byte write enables
//   wdata : row write data
//   rdata : registered row read data (holds until the next read)
// Contents and read register are intentionally not reset.
module scr1_dmem_resp_ram #(
    parameter int ROWS = 4096,
    parameter int VB   = 16
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(ROWS)-1:0]  addr,
    input  logic [VB-1:0]            be,
    input  logic [VB*8-1:0]          wdata,
    output logic [VB*8-1:0]          rdata
);

    logic [VB*8-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < VB; b++) begin
                    if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/scr1_memif.svh
// SCR1 memory interface types shared by the core and memory-side blocks.
//   type_scr1_mem_cmd_e   : read / write command
//   type_scr1_mem_width_e : access width (byte / halfword / word)
//   type_scr1_mem_resp_e  : response status
//   SCR1_DMEM_AWIDTH      : data-memory byte address width
`ifndef SCR1_MEMIF_SVH
`define SCR1_MEMIF_SVH

`define SCR1_DMEM_AWIDTH 32

typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
} type_scr1_mem_cmd_e;

typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
} type_scr1_mem_width_e;

typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
} type_scr1_mem_resp_e;

`endif

// File: rtl/scr1_dmem_resp.sv
// Data-memory responder: target side of the SCR1 dmem request/ack/response
// protocol. One request at a time, LATENCY wait states, then a one-cycle
// EXEC where the array is accessed, then a one-cycle response.
//   clk, rst      : clock, asynchronous active-high reset
//   dmem_req      : request valid (held until acked)
//   dmem_req_ack  : request accepted this cycle (combinational)
//   dmem_cmd      : RD / WR
//   dmem_width    : BYTE / HWORD / WORD
//   dmem_addr     : byte address
//   dmem_wdata    : write data (scalar in [31:0], vector full width)
//   dmem_rdata    : read data, non-zero only in a successful read response
//   dmem_resp     : NOTRDY / RDY_OK / RDY_ER
module scr1_dmem_resp
    import scr1_dmem_resp_pkg::*;
#(
    parameter int MEM_BYTES = 65536,
    parameter int VEC_BASE  = 32768,
    parameter int LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dmem_req,
    output logic                 dmem_req_ack,
    input  type_scr1_mem_cmd_e   dmem_cmd,
    input  type_scr1_mem_width_e dmem_width,
    input  logic [DMEM_AW-1:0]   dmem_addr,
    input  type_vector           dmem_wdata,
    output type_vector           dmem_rdata,
    output type_scr1_mem_resp_e  dmem_resp
);

    localparam int VW   = $bits(type_vector);
    localparam int VB   = VW / 8;
    localparam int ROWS = MEM_BYTES / VB;
    localparam int VBW  = $clog2(VB);
    localparam int MAW  = $clog2(MEM_BYTES);

    type_dmem_resp_st_e    state;
    logic [WCNT_W-1:0]     wcnt;
    type_scr1_mem_cmd_e    cmd_q;
    type_scr1_mem_width_e  width_q;
    logic [DMEM_AW-1:0]    addr_q;
    type_vector            wdata_q;

    logic                  accept;
    logic                  err;
    logic                  is_vec;
    logic [VBW-1:0]        woff;     // byte offset of the addressed word in its row
    logic [3:0]            be4;
    logic [31:0]           data32;
    logic [VB-1:0]         ram_be;
    type_vector            ram_wdata;
    type_vector            ram_rdata;
    logic [31:0]           rd_word;

    assign accept       = dmem_req && !rst && ((state == ST_IDLE) || (state == ST_RESP));
    assign dmem_req_ack = accept;

    assign err    = f_dmem_chk(addr_q, width_q, DMEM_AW'(MEM_BYTES),
                               DMEM_AW'(VEC_BASE), DMEM_AW'(VB));
    assign is_vec = (addr_q >= DMEM_AW'(VEC_BASE));
    assign woff   = addr_q[VBW-1:0] & ~VBW'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            cmd_q   <= SCR1_MEM_CMD_RD;
            width_q <= SCR1_MEM_WIDTH_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        cmd_q   <= dmem_cmd;
                        width_q <= dmem_width;
                        addr_q  <= dmem_addr;
                        wdata_q <= dmem_wdata;
                        if (LATENCY > 0) begin
                            state <= ST_WAIT;
                            wcnt  <= WCNT_W'(LATENCY);
                        end else begin
                            state <= ST_EXEC;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    wcnt <= wcnt - 1'b1;
                    if (wcnt == WCNT_W'(1)) state <= ST_EXEC;
                end
                ST_EXEC: state <= ST_RESP;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Scalar lanes: initiator supplies data right-aligned; place it at the
    // addressed byte lanes and replicate across the row, then select the
    // word with byte enables.
    always_comb begin
        be4 = 4'b0000;
        case (width_q)
            SCR1_MEM_WIDTH_BYTE:  be4 = 4'b0001;
            SCR1_MEM_WIDTH_HWORD: be4 = 4'b0011;
            SCR1_MEM_WIDTH_WORD:  be4 = 4'b1111;
            default:              be4 = 4'b0000;
        endcase
        be4    = be4 << addr_q[1:0];
        data32 = wdata_q[31:0] << {addr_q[1:0], 3'b000};
        if (is_vec) begin
            ram_be    = '1;
            ram_wdata = wdata_q;
        end else begin
            ram_be    = VB'(be4) << woff;
            ram_wdata = {(VB/4){data32}};
        end
    end

    scr1_dmem_resp_ram #(
        .ROWS (ROWS),
        .VB   (VB)
    ) u_ram (
        .clk   (clk),
        .en    ((state == ST_EXEC) && !err),
        .we    (cmd_q == SCR1_MEM_CMD_WR),
        .addr  (addr_q[MAW-1:VBW]),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign rd_word = 32'(ram_rdata >> {woff, 3'b000});

    always_comb begin
        dmem_resp  = SCR1_MEM_RESP_NOTRDY;
        dmem_rdata = '0;
        if (state == ST_RESP) begin
            dmem_resp = err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            if (!err && (cmd_q == SCR1_MEM_CMD_RD)) begin
                dmem_rdata = is_vec ? ram_rdata : {{(VW-32){1'b0}}, rd_word};
            end
        end
    end

endmodule

// File: doc/scr1_dmem_resp.md
# scr1_dmem_resp

Data-memory responder for the SCR1 data memory interface: the target end of the `dmem_*` request/ack/response protocol that the core top drives as initiator.
- Accepts one request at a time and services it from an internal byte-addressable array after a configurable number of wait states.
- Returns `RDY_OK` or `RDY_ER`.
- Supports scalar byte/halfword/word accesses plus full-row `type_vector` accesses in an upper vector window.
- Sits in the testbench/SoC memory subsystem, directly on the core's `dmem_*` ports.

## Interface
- `MEM_BYTES`, 65536: array size in bytes; power of two, multiple of VB.
- `VEC_BASE`, 32768: first byte address of the vector window; row-aligned, below `MEM_BYTES`.
- `LATENCY`, 1: wait states between acceptance and response, range 0..15.
- Derived: VW = `$bits(type_vector)` (multiple of 32); VB = VW/8 (row bytes).

Ports:
- `clk` input 1: sole clock.
- `rst` input 1: reset, asynchronous, active-high.
- `dmem_req` input 1: request valid; held by initiator until acked.
- `dmem_req_ack` output 1: request accepted this cycle.
- `dmem_cmd` input `type_scr1_mem_cmd_e`: `SCR1_MEM_CMD_RD` / `SCR1_MEM_CMD_WR`.
- `dmem_width` input `type_scr1_mem_width_e`: BYTE / HWORD / WORD.
- `dmem_addr` input `SCR1_DMEM_AWIDTH`: byte address.
- `dmem_wdata` input `type_vector`: write data; scalar uses bits [31:0].
- `dmem_rdata` output `type_vector`: read data, valid only in the response cycle.
- `dmem_resp` output `type_scr1_mem_resp_e`: NOTRDY / RDY_OK / RDY_ER.

## Operation
- FSM states and transitions:
  - **IDLE**: on accept, go to WAIT if `LATENCY` > 0, else go to EXEC.
  - **WAIT**: decrement `wcnt`; go to EXEC when `wcnt` reaches 1.
  - **EXEC**: single cycle; go to RESP.
  - **RESP**: go to EXEC/WAIT on a new accept, else go to IDLE.
- `dmem_req_ack` = `dmem_req` while in IDLE or RESP, and not in `rst`. This is combinational; cmd/width/addr/wdata are latched on the accept edge.
- Error checks, evaluated on the latched request; any failure gives RDY_ER, no array write, and `dmem_rdata` = 0:
  - `addr` ≥ `MEM_BYTES`.
  - Scalar region (`addr` < `VEC_BASE`): HWORD with `addr[0]`≠0, or WORD with `addr[1:0]`≠0.
  - Vector window (`addr` ≥ `VEC_BASE`): width ≠ WORD, or `addr` not VB-aligned.
- Scalar write: byte enables derived from width and `addr[1:0]` within the 32-bit word `addr[..:2]`. Lanes are taken from `wdata` shifted by `addr[1:0]`×8, matching the SCR1 LSU placement.
- Scalar read: the whole aligned 32-bit word is returned in `rdata[31:0]` with upper bits 0. The initiator extracts and extends.
- Vector access: the full VB-byte row is read or written; all byte enables are set.
- Array access (read sample or write commit) occurs on the clock edge leaving EXEC. Read data is registered into `dmem_rdata`.

## Timing
- Reset values:
  - State IDLE, `wcnt` = 0.
  - `dmem_resp` = NOTRDY, `dmem_rdata` = 0, `dmem_req_ack` = 0.
  - Array contents are not reset.
- Latency: accept at cycle N gives the response at cycle N+2+`LATENCY`. `dmem_resp` ≠ NOTRDY for exactly one cycle.
- Back-to-back: a request present during RESP is acked in that cycle. Its response arrives `LATENCY`+2 cycles later; there is no idle bubble beyond that.
- `dmem_req` low during RESP: return to IDLE.
- `rst` asserted mid-transaction: pending request dropped, no write committed unless the EXEC edge already occurred, outputs return to reset values immediately.
- A write followed immediately by a read of the same address returns the new data, since each commit precedes the next EXEC.
- Request inputs are ignored outside the accept cycle.

## Structure
- Types `type_scr1_mem_cmd_e`, `_width_e`, and `_resp_e` come from `scr1_memif.svh`; `type_vector` comes from `defines.svh`. These are not redefined.
- New package `scr1_dmem_resp_pkg` holds:
  - the state enum;
  - the `wcnt` width;
  - the error-check function `f_dmem_chk(addr, width) -> logic`.
- Sub-module `scr1_dmem_resp_ram`:
  - single-port, VW-wide rows, per-byte write enable, registered read;
  - instantiated once;
  - behavioural array with no reset.

## Test plan
- Reset release with `LATENCY`=1; WR WORD `addr` 0x10, `wdata` 0xDEADBEEF, then RD WORD 0x10 → ack same cycle, RDY_OK at N+3 both times, `rdata[31:0]` = 0xDEADBEEF.
- BYTE write 0xA5 at 0x13 over word 0x11223344 at 0x10, then RD WORD 0x10 → 0xA5223344.
- HWORD RD at 0x11, WORD WR at 0x12, and RD at 0x10000 → RDY_ER each; `rdata` = 0; a later read confirms memory unchanged.
- Vector window: WR WORD at `VEC_BASE` with alternating 0x5A/0xA5 bytes, RD back → full VW match. BYTE at `VEC_BASE` and WORD at `VEC_BASE`+4 → RDY_ER.
- Back-to-back with `LATENCY`=0 and `dmem_req` held high for 4 reads → acks 2 cycles apart, one RDY_OK per ack, no lost or duplicated responses.
- Assert `rst` during WAIT of a write with `LATENCY`=3 → resp NOTRDY and ack 0 immediately; a subsequent read shows old data.
